regfile_init_checker: RTL and testbench

REGFILE_INIT_CHECKER -- requirements
Module: regfile_init_checker

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_err_accum.sv | 62 ++++++
 rtl/regfile_init_checker.sv | 136 +++++++++++++
 tb/tb_regfile_init_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and the fill-pattern helper for the
// register-file init checker.
package regfile_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned ZREG  = 31;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNTW  = 6;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDone
    } state_e;

    // Fill pattern: plain index, or Seed+index (wraps mod 2^XLEN).
    function automatic logic [XLEN-1:0] pattern(input logic mode,
                                               input logic [XLEN-1:0] seed,
                                               input logic [AW-1:0] idx);
        logic [XLEN-1:0] ext;
        ext = {{(XLEN-AW){1'b0}}, idx};
        return mode ? (seed + ext) : ext;
    endfunction

endpackage

// File: rtl/regfile_err_accum.sv
// Read-back comparator: counts mismatching buses and records the lowest
// mismatching register index of the current pass.
module regfile_err_accum
    import regfile_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            check_i,
    input  logic [AW-2:0]   pair_i,
    input  logic [XLEN-1:0] bus_a_i,
    input  logic [XLEN-1:0] bus_b_i,
    input  logic [XLEN-1:0] exp_a_i,
    input  logic [XLEN-1:0] exp_b_i,
    output logic [CNTW-1:0] err_count_o,
    output logic [AW-1:0]   first_err_o
);

    logic            mis_a;
    logic            mis_b;
    logic [CNTW:0]   sum;
    logic [CNTW-1:0] err_count_d, err_count_q;
    logic [AW-1:0]   first_err_d, first_err_q;

    // Next error count / first-error index from this cycle's compare.
    always_comb begin
        mis_a       = check_i && (bus_a_i != exp_a_i);
        mis_b       = check_i && (bus_b_i != exp_b_i);
        sum         = {1'b0, err_count_q} + {{CNTW{1'b0}}, mis_a} + {{CNTW{1'b0}}, mis_b};
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        if (clear_i) begin
            err_count_d = '0;
            first_err_d = '0;
        end else if (check_i) begin
            err_count_d = (sum > (CNTW+1)'(NREGS)) ? CNTW'(NREGS) : sum[CNTW-1:0];
            // Only the first mismatch of a pass sets the index; A (even) beats B.
            if (err_count_q == '0) begin
                if (mis_a) begin
                    first_err_d = {pair_i, 1'b0};
                end else if (mis_b) begin
                    first_err_d = {pair_i, 1'b1};
                end
            end
        end
    end

    // Accumulator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_q <= '0;
            first_err_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_count_o = err_count_q;
    assign first_err_o = first_err_q;

endmodule

// File: rtl/regfile_init_checker.sv
// Fill-and-check engine: writes a pattern into every register, reads the
// file back in pairs and reports mismatch statistics.
module regfile_init_checker #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned ZREG  = 31
) (
    input  logic                          Clk,
    input  logic                          Resetn,
    input  logic                          Start,
    input  logic                          Mode,
    input  logic [regfile_pkg::XLEN-1:0]  Seed,
    output logic [regfile_pkg::AW-1:0]    RW,
    output logic [regfile_pkg::XLEN-1:0]  BusW,
    output logic                          RegWr,
    output logic [regfile_pkg::AW-1:0]    RA,
    output logic [regfile_pkg::AW-1:0]    RB,
    input  logic [regfile_pkg::XLEN-1:0]  BusA,
    input  logic [regfile_pkg::XLEN-1:0]  BusB,
    output logic                          Busy,
    output logic                          Done,
    output logic                          Pass,
    output logic [regfile_pkg::CNTW-1:0]  ErrCount,
    output logic [regfile_pkg::AW-1:0]    FirstErr
);
    import regfile_pkg::*;

    localparam logic [AW-1:0] LastIdx  = AW'(NREGS - 1);
    localparam logic [AW-2:0] LastPair = (AW-1)'(NREGS / 2 - 1);

    state_e          state_d, state_q;
    logic [AW-1:0]   idx_d, idx_q;
    logic            mode_d, mode_q;
    logic [XLEN-1:0] seed_d, seed_q;
    logic            pass_d, pass_q;
    logic            start_pass;
    logic            in_write;
    logic            in_read;
    logic [AW-1:0]   addr_a;
    logic [AW-1:0]   addr_b;
    logic [XLEN-1:0] exp_a;
    logic [XLEN-1:0] exp_b;

    // Next-state logic for the pass sequencer and latched pattern controls.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        seed_d     = seed_q;
        pass_d     = pass_q;
        start_pass = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    start_pass = 1'b1;
                    state_d    = StWrite;
                    idx_d      = '0;
                    mode_d     = Mode;
                    seed_d     = Seed;
                    pass_d     = 1'b0;
                end
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    state_d = StRead;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StRead: begin
                if (idx_q[AW-2:0] == LastPair) begin
                    state_d = StDone;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                pass_d  = (ErrCount == '0);
            end
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            seed_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            seed_q  <= seed_d;
            pass_q  <= pass_d;
        end
    end

    // Port decode from registered state; the zero register expects 0 on read.
    always_comb begin
        in_write = (state_q == StWrite);
        in_read  = (state_q == StRead);
        addr_a   = {idx_q[AW-2:0], 1'b0};
        addr_b   = {idx_q[AW-2:0], 1'b1};
        exp_a    = (addr_a == AW'(ZREG)) ? '0 : pattern(mode_q, seed_q, addr_a);
        exp_b    = (addr_b == AW'(ZREG)) ? '0 : pattern(mode_q, seed_q, addr_b);
        RegWr    = in_write;
        RW       = in_write ? idx_q : '0;
        BusW     = in_write ? pattern(mode_q, seed_q, idx_q) : '0;
        RA       = in_read ? addr_a : '0;
        RB       = in_read ? addr_b : '0;
        Busy     = in_write || in_read;
        Done     = (state_q == StDone);
        // pass_q is cleared at Start, so during DONE the live count decides.
        Pass     = pass_q || (Done && (ErrCount == '0));
    end

    regfile_err_accum u_err_accum (
        .clk_i       (Clk),
        .rst_ni      (Resetn),
        .clear_i     (start_pass),
        .check_i     (in_read),
        .pair_i      (idx_q[AW-2:0]),
        .bus_a_i     (BusA),
        .bus_b_i     (BusB),
        .exp_a_i     (exp_a),
        .exp_b_i     (exp_b),
        .err_count_o (ErrCount),
        .first_err_o (FirstErr)
    );

endmodule

// File: tb/tb_regfile_init_checker.sv
// Directed bench: behavioural 32x64 register file (reg 31 reads zero) with
// per-register fault overrides around the init checker.
module tb_regfile_init_checker;

    logic        Clk;
    logic        Resetn;
    logic        Start;
    logic        Mode;
    logic [63:0] Seed;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [5:0]  ErrCount;
    logic [4:0]  FirstErr;

    logic [63:0] mem       [32];
    logic [63:0] force_val [32];
    logic [31:0] force_en;

    int total = 0;
    int bad   = 0;

    regfile_init_checker #(
        .NREGS (32),
        .ZREG  (31)
    ) dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .Start    (Start),
        .Mode     (Mode),
        .Seed     (Seed),
        .RW       (RW),
        .BusW     (BusW),
        .RegWr    (RegWr),
        .RA       (RA),
        .RB       (RB),
        .BusA     (BusA),
        .BusB     (BusB),
        .Busy     (Busy),
        .Done     (Done),
        .Pass     (Pass),
        .ErrCount (ErrCount),
        .FirstErr (FirstErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register file: write on falling edge, combinational reads.
    always @(negedge Clk) begin
        if (RegWr) mem[RW] <= BusW;
    end

    always_comb begin
        BusA = (RA == 5'd31) ? 64'h0 : mem[RA];
        if (force_en[RA]) BusA = force_val[RA];
        BusB = (RB == 5'd31) ? 64'h0 : mem[RB];
        if (force_en[RB]) BusB = force_val[RB];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full pass. opt: 0 plain, 1 Start pulses in READ and DONE,
    // 2 Start raised in DONE and left high on return.
    task automatic run_pass(input string tag, input logic m, input logic [63:0] s,
                            input int exp_err, input int exp_first, input logic exp_pass,
                            input int opt);
        int          wbad;
        int          rbad;
        logic [63:0] w16;
        logic [63:0] wexp;
        Mode  = m;
        Seed  = s;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        Mode  = ~m;
        Seed  = ~s;
        check({tag, "_clr_err"}, {58'h0, ErrCount}, 64'd0);
        check({tag, "_clr_first"}, {59'h0, FirstErr}, 64'd0);
        check({tag, "_clr_pass"}, {63'h0, Pass}, 64'd0);
        wbad = 0;
        w16  = '0;
        for (int i = 0; i < 32; i++) begin
            wexp = m ? (s + 64'(i)) : 64'(i);
            if (RegWr !== 1'b1 || RW !== 5'(i) || BusW !== wexp || Busy !== 1'b1 ||
                RA !== 5'd0 || RB !== 5'd0 || Done !== 1'b0) wbad++;
            if (i == 16) w16 = BusW;
            @(posedge Clk); #1;
        end
        check({tag, "_write_seq"}, 64'(wbad), 64'd0);
        check({tag, "_busw16"}, w16, m ? (s + 64'd16) : 64'd16);
        rbad = 0;
        for (int k = 0; k < 16; k++) begin
            if (RegWr !== 1'b0 || RW !== 5'd0 || BusW !== 64'd0 || RA !== 5'(2*k) ||
                RB !== 5'(2*k+1) || Busy !== 1'b1 || Done !== 1'b0) rbad++;
            if (opt == 1 && k == 5) Start = 1'b1;
            @(posedge Clk); #1;
            Start = 1'b0;
        end
        check({tag, "_read_seq"}, 64'(rbad), 64'd0);
        check({tag, "_done"}, {63'h0, Done}, 64'd1);
        check({tag, "_done_busy"}, {63'h0, Busy}, 64'd0);
        check({tag, "_pass"}, {63'h0, Pass}, {63'h0, exp_pass});
        check({tag, "_errcnt"}, {58'h0, ErrCount}, 64'(exp_err));
        check({tag, "_firsterr"}, {59'h0, FirstErr}, 64'(exp_first));
        if (opt != 0) Start = 1'b1;
        @(posedge Clk); #1;
        if (opt != 2) Start = 1'b0;
        check({tag, "_idle_done"}, {63'h0, Done}, 64'd0);
        check({tag, "_idle_busy"}, {63'h0, Busy}, 64'd0);
        check({tag, "_hold_pass"}, {63'h0, Pass}, {63'h0, exp_pass});
        check({tag, "_hold_err"}, {58'h0, ErrCount}, 64'(exp_err));
    endtask

    initial begin
        int cnt;
        Resetn   = 1'b0;
        Start    = 1'b0;
        Mode     = 1'b0;
        Seed     = '0;
        force_en = '0;
        for (int i = 0; i < 32; i++) begin
            mem[i]       = '0;
            force_val[i] = '0;
        end

        // Reset and idle.
        #2;
        check("rst_regwr", {63'h0, RegWr}, 64'd0);
        check("rst_busy", {63'h0, Busy}, 64'd0);
        repeat (3) @(posedge Clk);
        #1;
        Resetn = 1'b1;
        check("idle_outs", {RW, RA, RB, RegWr, Busy, Done, Pass, ErrCount, FirstErr}, 64'd0);
        check("idle_busw", BusW, 64'd0);
        cnt = 0;
        repeat (10) begin
            @(posedge Clk); #1;
            if (RegWr !== 1'b0) cnt++;
        end
        check("idle_no_wr", 64'(cnt), 64'd0);

        // Index pattern, then Seed+index with wrap at i=16.
        run_pass("m0", 1'b0, 64'h0, 0, 0, 1'b1, 0);
        run_pass("m1", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 1'b1, 0);

        // Stuck registers 10 and 11.
        force_en      = 32'h0000_0C00;
        force_val[10] = 64'h1000;
        force_val[11] = 64'h1000;
        run_pass("stuck10_11", 1'b0, 64'h0, 2, 10, 1'b0, 0);

        // Only register 31 returns nonzero.
        force_en      = 32'h8000_0000;
        force_val[31] = 64'h1F;
        run_pass("zreg", 1'b0, 64'h0, 1, 31, 1'b0, 0);
        force_en = '0;

        // Start ignored during READ and DONE.
        run_pass("ign", 1'b1, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b1, 1);

        // Start held through DONE restarts on the first IDLE cycle.
        run_pass("hold", 1'b0, 64'h0, 0, 0, 1'b1, 2);
        run_pass("restart", 1'b1, 64'h0000_0000_0000_0100, 0, 0, 1'b1, 0);

        // Reset mid-WRITE at i=13.
        Mode  = 1'b0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (13) @(posedge Clk);
        #1;
        check("abort_rw13", {59'h0, RW}, 64'd13);
        Resetn = 1'b0;
        #1;
        check("abort_regwr", {63'h0, RegWr}, 64'd0);
        check("abort_outs", {RW, RA, RB, Busy, Done, Pass, ErrCount, FirstErr}, 64'd0);
        check("abort_busw", BusW, 64'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Resetn = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(posedge Clk); #1;
            if (Done !== 1'b0 || Busy !== 1'b0) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'd0);
        run_pass("after_rst", 1'b0, 64'h0, 0, 0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
